// File: rtl/program_mem_responder_if.sv
// program_mem_responder_if: icache miss ports and program-memory read port; slave = responder view, master = environment view
interface program_mem_responder_if #(
  parameter int NUM_CONSUMERS = 2,
  parameter int ADDR_BITS     = 8,
  parameter int DATA_BITS     = 16
);
  logic [NUM_CONSUMERS-1:0]           consumer_read_valid;
  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_read_address;
  logic [NUM_CONSUMERS-1:0]           consumer_read_ready;
  logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_read_data;
  logic                               mem_read_valid;
  logic [ADDR_BITS-1:0]               mem_read_address;
  logic                               mem_read_ready;
  logic [DATA_BITS-1:0]               mem_read_data;
  modport slave (
    input  consumer_read_valid, consumer_read_address, mem_read_ready, mem_read_data,
    output consumer_read_ready, consumer_read_data, mem_read_valid, mem_read_address
  );
  modport master (
    output consumer_read_valid, consumer_read_address, mem_read_ready, mem_read_data,
    input  consumer_read_ready, consumer_read_data, mem_read_valid, mem_read_address
  );
endinterface

// File: rtl/program_mem_responder.sv
// program_mem_responder: round-robin arbiter of icache miss ports onto one program-memory read port; clk/reset, bus (slave), total_reads/busy_cycles counters
module program_mem_responder #(
  parameter int NUM_CONSUMERS = 2,
  parameter int ADDR_BITS     = 8,
  parameter int DATA_BITS     = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  program_mem_responder_if.slave  bus,
  output logic [31:0]             total_reads,
  output logic [31:0]             busy_cycles
);
  localparam int IW = NUM_CONSUMERS > 1 ? $clog2(NUM_CONSUMERS) : 1;
  typedef enum logic [1:0] {IDLE, READ_WAITING, RELAYING} state_t;
  state_t                             state_q, state_d;
  logic [IW-1:0]                      grant_q, grant_d, rr_q, rr_d, win, cand;
  logic                               found;
  logic [NUM_CONSUMERS-1:0]           ready_q, ready_d;
  logic [NUM_CONSUMERS*DATA_BITS-1:0] data_q, data_d;
  logic                               mvalid_q, mvalid_d;
  logic [ADDR_BITS-1:0]               maddr_q, maddr_d;
  logic [31:0]                        reads_q, reads_d, busy_q, busy_d;
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      rr_q     <= '0;
      ready_q  <= '0;
      data_q   <= '0;
      mvalid_q <= 1'b0;
      maddr_q  <= '0;
      reads_q  <= '0;
      busy_q   <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_q     <= rr_d;
      ready_q  <= ready_d;
      data_q   <= data_d;
      mvalid_q <= mvalid_d;
      maddr_q  <= maddr_d;
      reads_q  <= reads_d;
      busy_q   <= busy_d;
    end
  end
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    rr_d     = rr_q;
    ready_d  = ready_q;
    data_d   = data_q;
    mvalid_d = mvalid_q;
    maddr_d  = maddr_q;
    reads_d  = reads_q;
    busy_d   = busy_q;
    win      = rr_q;
    cand     = '0;
    found    = 1'b0;
    // scan from the farthest offset down so the requester nearest rr_q wins last
    for (int i = NUM_CONSUMERS - 1; i >= 0; i--) begin
      cand = IW'((int'(rr_q) + i) % NUM_CONSUMERS);
      if (bus.consumer_read_valid[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
    case (state_q)
      IDLE: if (found) begin
        grant_d  = win;
        maddr_d  = bus.consumer_read_address[win*ADDR_BITS +: ADDR_BITS];
        mvalid_d = 1'b1;
        state_d  = READ_WAITING;
      end
      READ_WAITING: begin
        busy_d = busy_q + 32'd1;
        if (bus.mem_read_ready) begin
          mvalid_d                                 = 1'b0;
          data_d[grant_q*DATA_BITS +: DATA_BITS]   = bus.mem_read_data;
          ready_d[grant_q]                         = 1'b1;
          reads_d                                  = reads_q + 32'd1;
          state_d                                  = RELAYING;
        end
      end
      RELAYING: if (!bus.consumer_read_valid[grant_q]) begin
        ready_d[grant_q] = 1'b0;
        rr_d             = IW'((int'(grant_q) + 1) % NUM_CONSUMERS);
        state_d          = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  assign bus.consumer_read_ready = ready_q;
  assign bus.consumer_read_data  = data_q;
  assign bus.mem_read_valid      = mvalid_q;
  assign bus.mem_read_address    = maddr_q;
  assign total_reads             = reads_q;
  assign busy_cycles             = busy_q;
endmodule

// File: tb/tb_program_mem_responder.sv
// tb_program_mem_responder: directed self-checking bench for program_mem_responder
module tb_program_mem_responder;
  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] total_reads, busy_cycles;
  int          n_pass = 0, n_total = 0;
  program_mem_responder_if #(.NUM_CONSUMERS(2), .ADDR_BITS(8), .DATA_BITS(16)) bus ();
  program_mem_responder #(.NUM_CONSUMERS(2), .ADDR_BITS(8), .DATA_BITS(16)) dut (
    .clk(clk), .reset(reset), .bus(bus), .total_reads(total_reads), .busy_cycles(busy_cycles)
  );
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask
  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask
  // hold mem_read_ready so the responder spends lat cycles in READ_WAITING
  task automatic mem_serve(input int lat, input logic [15:0] d);
    int k;
    k = 0;
    while (!bus.mem_read_valid && k < 20) begin
      step();
      k++;
    end
    if (!bus.mem_read_valid) check("mem_valid_timeout", 32'd0, 32'd1);
    for (int j = 1; j < lat; j++) step();
    bus.mem_read_ready = 1'b1;
    bus.mem_read_data  = d;
    step();
    bus.mem_read_ready = 1'b0;
    bus.mem_read_data  = '0;
  endtask
  initial begin
    bus.consumer_read_valid   = '0;
    bus.consumer_read_address = '0;
    bus.mem_read_ready        = 1'b0;
    bus.mem_read_data         = '0;
    do_reset();
    check("rst_ready", 32'(bus.consumer_read_ready), 32'd0);
    check("rst_data", bus.consumer_read_data, 32'd0);
    check("rst_mvalid", 32'(bus.mem_read_valid), 32'd0);
    check("rst_maddr", 32'(bus.mem_read_address), 32'd0);
    check("rst_reads", total_reads, 32'd0);
    check("rst_busy", busy_cycles, 32'd0);
    // single request, latency 3
    bus.consumer_read_valid   = 2'b01;
    bus.consumer_read_address = 16'h0012;
    step();
    check("t1_mvalid", 32'(bus.mem_read_valid), 32'd1);
    check("t1_maddr", 32'(bus.mem_read_address), 32'h12);
    mem_serve(3, 16'hBEEF);
    check("t1_ready", 32'(bus.consumer_read_ready), 32'h1);
    check("t1_data", 32'(bus.consumer_read_data[15:0]), 32'hBEEF);
    check("t1_mvalid_low", 32'(bus.mem_read_valid), 32'd0);
    step();
    check("t1_ready_hold", 32'(bus.consumer_read_ready), 32'h1);
    bus.consumer_read_valid = 2'b00;
    step();
    check("t1_ready_low", 32'(bus.consumer_read_ready), 32'h0);
    check("t1_reads", total_reads, 32'd1);
    check("t1_busy", busy_cycles, 32'd3);
    // icache-style: drop valid one cycle after ready is seen
    bus.consumer_read_valid   = 2'b01;
    bus.consumer_read_address = 16'h0020;
    step();
    check("t2_maddr", 32'(bus.mem_read_address), 32'h20);
    mem_serve(2, 16'h1234);
    check("t2_ready1", 32'(bus.consumer_read_ready), 32'h1);
    check("t2_data1", 32'(bus.consumer_read_data[15:0]), 32'h1234);
    step();
    check("t2_ready2", 32'(bus.consumer_read_ready), 32'h1);
    check("t2_data2", 32'(bus.consumer_read_data[15:0]), 32'h1234);
    bus.consumer_read_valid = 2'b00;
    step();
    check("t2_ready3", 32'(bus.consumer_read_ready), 32'h0);
    // simultaneous requests from reset
    do_reset();
    bus.consumer_read_valid   = 2'b11;
    bus.consumer_read_address = 16'h0605;
    step();
    check("t3_g0_addr", 32'(bus.mem_read_address), 32'h05);
    mem_serve(1, 16'hA005);
    check("t3_g0_ready", 32'(bus.consumer_read_ready), 32'h1);
    check("t3_g0_data", 32'(bus.consumer_read_data[15:0]), 32'hA005);
    bus.consumer_read_valid = 2'b10;
    step();
    check("t3_g0_done", 32'(bus.consumer_read_ready), 32'h0);
    bus.consumer_read_valid   = 2'b11;
    bus.consumer_read_address = 16'h0607;
    step();
    check("t3_g1_addr", 32'(bus.mem_read_address), 32'h06);
    mem_serve(1, 16'hB006);
    check("t3_g1_ready", 32'(bus.consumer_read_ready), 32'h2);
    check("t3_g1_data", 32'(bus.consumer_read_data[31:16]), 32'hB006);
    check("t3_g1_d0", 32'(bus.consumer_read_data[15:0]), 32'hA005);
    bus.consumer_read_valid = 2'b01;
    step();
    step();
    check("t3_g0b_addr", 32'(bus.mem_read_address), 32'h07);
    mem_serve(1, 16'hC007);
    check("t3_g0b_ready", 32'(bus.consumer_read_ready), 32'h1);
    check("t3_g0b_data", 32'(bus.consumer_read_data[15:0]), 32'hC007);
    bus.consumer_read_valid = 2'b00;
    step();
    check("t3_reads", total_reads, 32'd3);
    // early drop during READ_WAITING
    bus.consumer_read_valid   = 2'b10;
    bus.consumer_read_address = 16'h3000;
    step();
    check("t4_maddr", 32'(bus.mem_read_address), 32'h30);
    bus.consumer_read_valid = 2'b00;
    mem_serve(2, 16'hD030);
    check("t4_ready", 32'(bus.consumer_read_ready), 32'h2);
    check("t4_data", 32'(bus.consumer_read_data[31:16]), 32'hD030);
    step();
    check("t4_pulse_end", 32'(bus.consumer_read_ready), 32'h0);
    check("t4_d0", 32'(bus.consumer_read_data[15:0]), 32'hC007);
    check("t4_reads", total_reads, 32'd4);
    // reset in the middle of a read
    bus.consumer_read_valid   = 2'b01;
    bus.consumer_read_address = 16'h0040;
    step();
    check("t5_mvalid", 32'(bus.mem_read_valid), 32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    bus.consumer_read_valid = 2'b00;
    check("t5_ready", 32'(bus.consumer_read_ready), 32'h0);
    check("t5_data", bus.consumer_read_data, 32'h0);
    check("t5_mvalid0", 32'(bus.mem_read_valid), 32'd0);
    check("t5_maddr", 32'(bus.mem_read_address), 32'h0);
    check("t5_reads", total_reads, 32'd0);
    check("t5_busy", busy_cycles, 32'd0);
    bus.mem_read_ready = 1'b1;
    bus.mem_read_data  = 16'hEEEE;
    step();
    bus.mem_read_ready = 1'b0;
    check("t5_late_ready", 32'(bus.consumer_read_ready), 32'h0);
    check("t5_late_data", bus.consumer_read_data, 32'h0);
    step();
    check("t5_late_ready2", 32'(bus.consumer_read_ready), 32'h0);
    check("t5_late_reads", total_reads, 32'd0);
    // back-to-back reads from consumer 0, latency 1
    for (int k = 0; k < 4; k++) begin
      bus.consumer_read_valid   = 2'b01;
      bus.consumer_read_address = 16'(8'h50 + k);
      step();
      check("t6_maddr", 32'(bus.mem_read_address), 32'h50 + k);
      mem_serve(1, 16'h1000 + 16'(k));
      check("t6_data", 32'(bus.consumer_read_data[15:0]), 32'h1000 + k);
      check("t6_ready", 32'(bus.consumer_read_ready), 32'h1);
      bus.consumer_read_valid = 2'b00;
      step();
      check("t6_ready_low", 32'(bus.consumer_read_ready), 32'h0);
    end
    check("t6_reads", total_reads, 32'd4);
    check("t6_busy", busy_cycles, 32'd4);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
